cbus_uart_rx: RTL and testbench
===============================

Name: cbus_uart_rx

Overview:
- Serial receive-side peripheral for the device region: samples an 8N1 UART line `rx`, deframes bytes and buffers them in a FIFO.
- Exposes received bytes and status to the CPU as a single-beat responder on the device-side bus (valid/addr/wdata/wvalid/rdata/ready/last).
- Receive counterpart to the existing `tx` path; sits beside the device block behind the crossbar.

Parameters:
- CLK_DIV, 27, cpu_clk cycles per 1/16 bit time (oversample tick period); legal range 1..65535.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  cpu clock; all logic in this domain.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- valid  input  1  request valid; held by the initiator until ready.
- addr  input  64  byte address; only addr[3] is decoded (0 = RXDATA, 1 = STATUS).
- wdata  input  64  write data.
- wvalid  input  1  1 = write, 0 = read; qualified by valid.
- rdata  output  64  read data, valid while ready=1.
- ready  output  1  one-cycle response strobe.
- last  output  1  equals ready (single-beat only).
- rx  input  1  asynchronous serial input, idle high.
- irq  output  1  level: FIFO non-empty OR any error flag set.

Behaviour:
- Reset (reset=0, immediate): ready=0, last=0, rdata=0, irq=0. FIFO is emptied, error flags are cleared, and the RX FSM goes to IDLE. The tick counter and synchronizers are set to idle-high.
- Deasserting reset mid-frame discards the partial byte; the FSM waits for the next falling edge.
- rx passes through a 2-flop synchronizer before use. The tick counter pulses once every CLK_DIV cycles and free-runs outside IDLE.

RX FSM:
- IDLE: on a synchronized falling edge, go to START and zero the tick count.
- START: at tick 8, if rx=0 go to DATA; otherwise treat it as a glitch and return to IDLE.
- DATA: sample every 16 ticks, LSB first; after 8 bits go to STOP (or PARITY when the option is enabled).
- STOP: sample at mid-bit.
  - If rx=1, push the byte to the FIFO.
  - If rx=0, set frame_err, drop the byte, and wait in IDLE-arm until rx=1 before rearming.
- Push while full drops the new byte and sets overrun. Exception: a bus pop in the same cycle frees a slot, so the push is accepted.

Bus responder:
- Cycle N: valid=1 with ready=0 is sampled. Cycle N+1: ready=last=1 for exactly one cycle with rdata driven.
- The responder then ignores valid for one cycle, so a held request is not double-serviced. Maximum throughput is 1 transaction per 2 cycles.
- Read RXDATA (addr[3]=0):
  - rdata = {55'b0, nonempty, head_byte}.
  - Pops one entry if nonempty.
  - If empty, returns 64'h0 and does not pop.
- Read STATUS (addr[3]=1):
  - rdata[0] = nonempty
  - rdata[1] = overrun
  - rdata[2] = frame_err
  - rdata[3] = parity_err
  - rdata[4] = full
  - rdata[23:8] = FIFO count (zero-extended)
  - all other bits 0
- Write STATUS: write-1-to-clear on bits [3:1] from wdata. Other bits are ignored. rdata=0.
- Write RXDATA: acknowledged, no effect, rdata=0.
- Flags are sticky until cleared. If a set event and a clear land in the same cycle, set wins.
- rdata holds its last value while ready=0 and is don't-care to the initiator.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit at mid-bit.
  - On mismatch, the byte is not pushed and parity_err (STATUS bit 3) is set; the stop bit is still checked.
  - A frame is 11 bits.
- Undefined: no parity state; STATUS bit 3 reads 0, and writes to it are ignored.

Test Plan:
- Send 0xA5 at CLK_DIV=4 (64 clk/bit) → STATUS read returns 0x0101; RXDATA read returns 0x1A5; a second RXDATA read returns 0x0 with count 0; irq falls after the pop.
- A 3-cycle low glitch on rx while idle → no push and no error; STATUS=0x0.
- Send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 and no reads → STATUS=0x1013 (count 16, full, overrun, nonempty); RXDATA pops 0x00..0x0F in order; write STATUS wdata=0x2 → overrun clears.
- Send 0x3C with the stop bit held low → frame_err set, STATUS=0x0004, irq=1; write wdata=0x4 → STATUS=0x0, irq=0.
- Assert reset (0) mid-byte and while ready=1 → ready/last/irq drop the same cycle; after release, a new 0x5A is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err set, FIFO empty; 0x07 with parity bit 1 → RXDATA=0x107.

Source files
------------

// File: rtl/cbus_uart_rx.sv
// 8N1 UART receiver with a receive FIFO, exposed as a single-beat device-bus responder.
// Optional even-parity frame support is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module cbus_uart_rx #(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        wvalid,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        last,
  input  logic        rx,
  output logic        irq
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_ARM} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic [15:0]     r_div_cnt;
  logic [3:0]      r_tick_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [CW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            r_ovr, r_frm, r_par, r_ready;
  logic [63:0]     r_rdata;
  logic            w_fall, w_div_wrap, w_tick, w_sample, w_push_req, w_frame_set;
  logic            w_par_set, w_par_bad, w_push_ok, w_ovr_set, w_pop, w_accept;
  logic            w_full, w_nonempty;
  logic [CW-1:0]   w_count;
  logic [2:0]      w_clr;
  logic [63:0]     w_status, w_resp;
  logic            w_unused;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_tick     = w_div_wrap && (r_state != S_IDLE);

  // Oversample counters stay parked at zero in IDLE so START begins on a clean tick phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 16'd1;
      if (r_state == S_START && w_sample) r_tick_cnt <= '0;
      else if (w_tick)                    r_tick_cnt <= r_tick_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_fall) w_state_nxt = S_START;
      S_START:  if (w_sample) w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_sample && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
`else
      S_DATA:   if (w_sample && r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
`endif
      S_PARITY: if (w_sample) w_state_nxt = S_STOP;
      S_STOP:   if (w_sample) w_state_nxt = r_rx_sync ? S_IDLE : S_ARM;
      S_ARM:    if (r_rx_sync) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sample    = 1'b0;
    w_push_req  = 1'b0;
    w_frame_set = 1'b0;
    unique case (r_state)
      S_START:                 w_sample = w_tick && (r_tick_cnt == 4'd7);
      S_DATA, S_PARITY, S_STOP: w_sample = w_tick && (r_tick_cnt == 4'd15);
      default:                 w_sample = 1'b0;
    endcase
    if (r_state == S_STOP && w_sample) begin
      w_push_req  = r_rx_sync & ~w_par_bad;
      w_frame_set = ~r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == S_START) begin
      r_bit_cnt <= '0;
    end else if (r_state == S_DATA && w_sample) begin
      r_shift   <= {r_rx_sync, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_set = (r_state == S_PARITY) && w_sample && (r_rx_sync != ^r_shift);
  assign w_par_bad = r_par_bad;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_par_bad <= 1'b0;
    else if (r_state == S_START) r_par_bad <= 1'b0;
    else if (w_par_set)          r_par_bad <= 1'b1;
  end
`else
  assign w_par_set = 1'b0;
  assign w_par_bad = 1'b0;
`endif

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_count == CW'(FIFO_DEPTH));
  assign w_nonempty = (w_count != '0);
  assign w_accept   = valid && !r_ready;
  assign w_pop      = w_accept && !wvalid && !addr[3] && w_nonempty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovr_set  = w_push_req && w_full && !w_pop;
  assign w_clr      = (w_accept && wvalid && addr[3]) ? wdata[3:1] : 3'b000;

  // NOTE: FIFO storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= 1'b0;
      r_frm    <= 1'b0;
      r_par    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + CW'(1);
      r_ovr <= (r_ovr & ~w_clr[0]) | w_ovr_set;
      r_frm <= (r_frm & ~w_clr[1]) | w_frame_set;
      r_par <= (r_par & ~w_clr[2]) | w_par_set;
    end
  end

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_nonempty;
    w_status[1]    = r_ovr;
    w_status[2]    = r_frm;
    w_status[3]    = r_par;
    w_status[4]    = w_full;
    w_status[23:8] = 16'(w_count);
    w_resp         = '0;
    if (!wvalid) begin
      if (addr[3])         w_resp = w_status;
      else if (w_nonempty) w_resp = {55'd0, 1'b1, r_mem[r_rd_ptr[AW-1:0]]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) r_rdata <= w_resp;
    end
  end

  assign ready    = r_ready;
  assign last     = r_ready;
  assign rdata    = r_rdata;
  assign irq      = w_nonempty | r_ovr | r_frm | r_par;
  assign w_unused = &{1'b0, addr[63:4], addr[2:0], wdata[63:4], wdata[0]};

endmodule

// File: tb/tb_cbus_uart_rx.sv
// Scoreboard bench for cbus_uart_rx: a queue-based model predicts bus responses, a monitor checks them.
`timescale 1ns/1ps
module tb_cbus_uart_rx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 16;
  localparam int BIT     = 16 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset, valid, wvalid, rx;
  logic [63:0] addr, wdata;
  logic [63:0] rdata;
  logic        ready, last, irq;

  cbus_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata),
    .wvalid(wvalid), .rdata(rdata), .ready(ready), .last(last), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [63:0]  sb[$];
  logic [63:0]  mon_exp;
  byte unsigned m_q[$];
  bit           m_ovr, m_frm, m_par;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s       = '0;
    s[0]    = (m_q.size() != 0);
    s[1]    = m_ovr;
    s[2]    = m_frm;
    s[3]    = m_par;
    s[4]    = (m_q.size() == DEPTH);
    s[23:8] = 16'(m_q.size());
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_q.size() != 0) || m_ovr || m_frm || m_par;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ovr = 0; m_frm = 0; m_par = 0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Effect of one complete frame on the peripheral, as the user sees it.
  task automatic apply_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    bit bad_par;
    bad_par = 0;
`ifdef UART_RX_PARITY_EN
    bad_par = (par_bit != ^d);
`endif
    if (bad_par) m_par = 1;
    if (!stop_bit) m_frm = 1;
    else if (!bad_par) begin
      if (m_q.size() == DEPTH) m_ovr = 1;
      else                     m_q.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    rx = 1'b0;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    hold(BIT);
`endif
    rx = stop_bit;
    hold(BIT);
    rx = 1'b1;
    apply_frame(d, par_bit, stop_bit);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  // One bus transaction; valid is held through the ready cycle to catch double servicing.
  task automatic bus(input bit we, input bit a3, input logic [63:0] wd);
    logic [63:0] exp;
    logic [7:0]  head;
    int          waited;
    exp = '0;
    if (we) begin
      if (a3) begin
        if (wd[1]) m_ovr = 0;
        if (wd[2]) m_frm = 0;
`ifdef UART_RX_PARITY_EN
        if (wd[3]) m_par = 0;
`endif
      end
    end else if (a3) begin
      exp = m_status();
    end else if (m_q.size() != 0) begin
      head = m_q.pop_front();
      exp  = {55'd0, 1'b1, head};
    end
    sb.push_back(exp);
    valid   = 1'b1;
    wvalid  = we;
    addr    = {$urandom(), $urandom()};
    addr[3] = a3;
    wdata   = wd;
    waited  = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!ready && waited < 8);
    check("bus_latency", 64'(waited), 64'd1);
    hold(1);
    valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && ready) begin
      check("last_eq_ready", {63'd0, last}, {63'd0, ready});
      if (sb.size() == 0) check("unexpected_ready", {63'd0, ready}, 64'd0);
      else begin
        mon_exp = sb.pop_front();
        check("rdata", rdata, mon_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; wvalid = 1'b0; rx = 1'b1; addr = '0; wdata = '0;
    m_reset();
    #2 reset = 1'b0;
    #3;
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_last",  {63'd0, last},  64'd0);
    check("rst_rdata", rdata,          64'd0);
    check("rst_irq",   {63'd0, irq},   64'd0);
    hold(5);
    reset = 1'b1;
    hold(5);

    // Single byte: status, pop, empty pop, irq falls.
    send_byte(8'hA5);
    check("a5_irq", {63'd0, irq}, {63'd0, m_irq()});
    bus(0, 1, '0);
    bus(0, 0, '0);
    bus(0, 0, '0);
    bus(0, 1, '0);
    check("a5_irq_after_pop", {63'd0, irq}, {63'd0, m_irq()});

    // Short low glitch while idle.
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(2 * BIT);
    bus(0, 1, '0);

    // Overflow by one.
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i));
    bus(0, 1, '0);
    for (int i = 0; i < DEPTH; i++) bus(0, 0, '0);
    bus(0, 1, '0);
    bus(1, 1, 64'h2);
    bus(0, 1, '0);

    // Framing error and its clear.
    send_frame(8'h3C, ^8'h3C, 1'b0);
    hold(BIT);
    check("frm_irq", {63'd0, irq}, {63'd0, m_irq()});
    bus(0, 1, '0);
    bus(1, 1, 64'h4);
    bus(0, 1, '0);
    check("frm_irq_clr", {63'd0, irq}, {63'd0, m_irq()});

    // Writes that must have no side effect besides W1C.
    send_byte(8'h81);
    bus(1, 0, '1);
    bus(1, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    bus(0, 1, '0);
    bus(0, 0, '0);

    // Reset mid-byte with a byte already buffered.
    send_byte(8'h11);
    check("pre_rst_irq", {63'd0, irq}, {63'd0, m_irq()});
    fork
      send_byte(8'h77);
      begin
        hold(BIT * 5);
        reset = 1'b0;
        #1;
        check("midbyte_rst_irq",   {63'd0, irq},   64'd0);
        check("midbyte_rst_ready", {63'd0, ready}, 64'd0);
      end
    join
    m_reset();
    hold(4);
    reset = 1'b1;
    hold(4);
    bus(0, 1, '0);

    // Reset while ready is high.
    send_byte(8'h22);
    valid = 1'b1; wvalid = 1'b0; addr = '0;
    @(posedge clk);
    #1;
    check("ready_pre_reset", {63'd0, ready}, 64'd1);
    reset = 1'b0;
    #1;
    valid = 1'b0;
    check("rst_drop_ready", {63'd0, ready}, 64'd0);
    check("rst_drop_last",  {63'd0, last},  64'd0);
    check("rst_drop_irq",   {63'd0, irq},   64'd0);
    check("rst_drop_rdata", rdata,          64'd0);
    m_reset();
    hold(3);
    reset = 1'b1;
    hold(3);
    send_byte(8'h5A);
    bus(0, 0, '0);
    bus(0, 1, '0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    bus(0, 1, '0);
    bus(1, 1, 64'h8);
    send_frame(8'h07, 1'b1, 1'b1);
    bus(0, 0, '0);
    bus(0, 1, '0);
`endif

    // Randomized frames interleaved with bus traffic.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int         mode;
      d    = 8'($urandom());
      mode = $urandom_range(0, 9);
      if (mode == 0) send_frame(d, ^d, 1'b0);
`ifdef UART_RX_PARITY_EN
      else if (mode == 1) send_frame(d, ~^d, 1'b1);
`endif
      else send_byte(d);
      hold($urandom_range(8, BIT));
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       bus(0, 0, '0);
          1:       bus(0, 1, '0);
          default: bus(1, 1, 64'($urandom_range(0, 15)));
        endcase
      end
    end
    bus(0, 1, '0);
    while (m_q.size() != 0) bus(0, 0, '0);
    bus(1, 1, 64'hE);
    bus(0, 1, '0);

    hold(20);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
